// File: rtl/kara8_seq_ctrl.sv
// kara8_seq_ctrl: 8x8 unsigned multiply via one-level Karatsuba over three passes of an external 4x4 core
module kara8_seq_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  output logic [3:0]  mul_a,
  output logic [3:0]  mul_b,
  input  logic [7:0]  mul_p,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] prod
);
  typedef enum logic [2:0] {IDLE, M_HI, M_LO, M_MID, DONE} state_t;
  state_t state;
  logic [3:0] xl, yl;
  logic [4:0] sx, sy;
  logic [7:0] z2, z0;
  logic [9:0] pm, z1;
  logic [15:0] prod_next;
  // The core only sees the low nibbles of sx/sy; carries are folded back in here.
  always_comb begin
    pm = 10'(mul_p)
       + ((10'(sx[4] ? sy[3:0] : 4'd0) + 10'(sy[4] ? sx[3:0] : 4'd0)) << 4)
       + (10'(sx[4] & sy[4]) << 8);
    z1 = pm - 10'(z2) - 10'(z0);
    prod_next = 16'((17'(z2) << 8) + (17'(z1) << 4) + 17'(z0));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      mul_a     <= 4'd0;
      mul_b     <= 4'd0;
      prod      <= 16'd0;
      xl        <= 4'd0;
      yl        <= 4'd0;
      sx        <= 5'd0;
      sy        <= 5'd0;
      z2        <= 8'd0;
      z0        <= 8'd0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          xl       <= x[3:0];
          yl       <= y[3:0];
          sx       <= 5'(x[7:4]) + 5'(x[3:0]);
          sy       <= 5'(y[7:4]) + 5'(y[3:0]);
          mul_a    <= x[7:4];
          mul_b    <= y[7:4];
          in_ready <= 1'b0;
          state    <= M_HI;
        end
        M_HI: begin
          z2    <= mul_p;
          mul_a <= xl;
          mul_b <= yl;
          state <= M_LO;
        end
        M_LO: begin
          z0    <= mul_p;
          mul_a <= sx[3:0];
          mul_b <= sy[3:0];
          state <= M_MID;
        end
        M_MID: begin
          prod      <= prod_next;
          mul_a     <= 4'd0;
          mul_b     <= 4'd0;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/kara8_seq_ctrl.md
KARA8_SEQ_CTRL -- requirements
Module: kara8_seq_ctrl

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operand pair x/y present.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 x  input  8  multiplicand, unsigned.
REQ-007 y  input  8  multiplier, unsigned.
REQ-008 mul_a  output  4  operand A to the external combinational 4x4 multiplier core.
REQ-009 mul_b  output  4  operand B to the external combinational 4x4 multiplier core.
REQ-010 mul_p  input  8  product from the core, valid in the same cycle as mul_a/mul_b.
REQ-011 out_valid  output  1  prod holds a finished result.
REQ-012 out_ready  input  1  consumer accepts prod.
REQ-013 prod  output  16  unsigned product x*y.

Function
REQ-014 Operation: 8x8 unsigned multiply by one-level Karatsuba using three sequential passes through one 4x4 core; xh=x[7:4], xl=x[3:0], yh=y[7:4], yl=y[3:0].
REQ-015 FSM states SHALL be IDLE, M_HI, M_LO, M_MID, DONE.
REQ-016 IDLE: in_ready=1; on in_valid=1, latch x and y, go to M_HI; otherwise stay.
REQ-017 in_ready SHALL be 0 in every state except IDLE; in_valid is ignored outside IDLE.
REQ-018 M_HI: mul_a=xh, mul_b=yh; capture z2=mul_p at end of cycle; go to M_LO.
REQ-019 M_LO: mul_a=xl, mul_b=yl; capture z0=mul_p; go to M_MID.
REQ-020 sx=xh+xl and sy=yh+yl SHALL be 5-bit, formed when operands are latched.
REQ-021 M_MID: mul_a=sx[3:0], mul_b=sy[3:0]; pm = mul_p + ((sx[4]?sy[3:0]:0)+(sy[4]?sx[3:0]:0))<<4 + (sx[4]&sy[4])<<8, 10-bit, no overflow possible (max 900).
REQ-022 z1 = pm - z2 - z0, 10-bit, never negative.
REQ-023 At end of M_MID: prod <= (z2<<8) + (z1<<4) + z0, computed in 17 bits and truncated to 16 (upper bit always 0); go to DONE.
REQ-024 DONE: out_valid=1, prod stable; on out_ready=1 go to IDLE; otherwise hold prod and out_valid.
REQ-025 Latency: acceptance at edge N yields out_valid=1 in the cycle after edge N+3; minimum accept-to-accept spacing is 5 cycles.
REQ-026 mul_a and mul_b SHALL be 0 in IDLE and DONE.
REQ-027 prod SHALL keep the last result after leaving DONE, until overwritten at the end of the next M_MID.
REQ-028 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-029 rst=1 at a rising edge SHALL force state IDLE, prod=0, out_valid=0, mul_a=0, mul_b=0, and clear the latched operands and partials; after that edge in_ready=1.
REQ-030 Reset SHALL take priority over every transition, including mid-operation and in DONE; an aborted operation produces no output.
REQ-031 in_valid during the rst=1 cycle SHALL NOT be accepted.

Verification
REQ-032 x=0x12, y=0x34, out_ready=1 -> mul_a/mul_b = 1/3, 2/4, 3/7 in M_HI/M_LO/M_MID; out_valid 4 cycles after accept; prod=0x03A8.
REQ-033 x=0xFF, y=0xFF (sx=sy=0x1E, both carries set) -> prod=0xFE01; x=0x00, y=0xAB -> prod=0x0000.
REQ-034 Backpressure: x=0x9C, y=0x7D, out_ready=0 for 6 cycles, then 1 -> prod=0x4C2C with out_valid held the whole time; in_ready=0 until the cycle after the handshake; new in_valid during the hold is ignored.
REQ-035 rst pulsed for 1 cycle in M_LO -> next cycle IDLE, out_valid=0, prod=0, in_ready=1; a following x=0x0F, y=0xF0 -> prod=0x0E10.
REQ-036 Randomised back-to-back run of 1000 pairs with random out_ready and a behavioural 4x4 core model -> every prod equals x*y, with no dropped or duplicated results.
